// File: rtl/switch_port_nx.sv
// Ingress port for the N-port switch: packet FIFO, head-of-line validation, and serialised
// per-output delivery. Optional ARB_WAIT timeout is enabled by defining SWITCH_PORT_TIMEOUT_EN.
module switch_port_nx #(
    parameter int NUM_PORTS      = 4,
    parameter int DATA_W         = 8,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NUM_PORTS-1:0] in_source,
    input  logic [NUM_PORTS-1:0] in_target,
    input  logic [DATA_W-1:0]    in_data,
    output logic [NUM_PORTS-1:0] req_out,
    input  logic [NUM_PORTS-1:0] grant_in,
    output logic                 tx_valid,
    output logic [NUM_PORTS-1:0] tx_target,
    output logic [NUM_PORTS-1:0] tx_source,
    output logic [DATA_W-1:0]    tx_data,
    output logic                 busy,
    output logic [15:0]          drop_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = DATA_W + 2 * NUM_PORTS;
    localparam logic [NUM_PORTS-1:0] ALL_PORTS = '1;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1 ||
        NUM_PORTS < 2 || NUM_PORTS > 16) begin : g_param_check
        $error("switch_port_nx: illegal parameter combination");
    end

    typedef enum logic [1:0] {IDLE, ROUTE, ARB_WAIT, TRANSMIT} state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t               state;
    logic [EW-1:0]        mem [FIFO_DEPTH];
    logic [AW:0]          wr_ptr, rd_ptr;
    logic                 full, empty, push, pop;
    logic [NUM_PORTS-1:0] head_source, head_target;
    logic [DATA_W-1:0]    head_data;
    logic                 head_ok;
    logic [NUM_PORTS-1:0] pending, pending_next;
    logic [NUM_PORTS-1:0] grant_eff, grant_sel;
    logic                 timeout;

    // The extra pointer bit tells a full FIFO apart from an empty one.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign in_ready = !full;
    assign push     = in_valid && !full;

    assign {head_data, head_target, head_source} = mem[rd_ptr[AW-1:0]];

    assign head_ok = (head_source != '0) &&
                     ((head_source & (head_source - NUM_PORTS'(1))) == '0) &&
                     (head_target != '0) &&
                     (((head_target & head_source) == '0) || (head_target == ALL_PORTS));

    assign grant_eff    = grant_in & pending;
    assign grant_sel    = grant_eff & (~grant_eff + NUM_PORTS'(1));
    assign pending_next = pending & ~tx_target;

    always_comb begin
        pop = 1'b0;
        if (state == ROUTE && !head_ok)
            pop = 1'b1;
        if (state == TRANSMIT && pending_next == '0)
            pop = 1'b1;
        if (timeout)
            pop = 1'b1;
    end

`ifdef SWITCH_PORT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wait_cnt;

    // Counter sits at zero outside ARB_WAIT, so every entry starts a fresh wait.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wait_cnt <= '0;
        else if (state != ARB_WAIT)
            wait_cnt <= '0;
        else if (grant_eff == '0)
            wait_cnt <= wait_cnt + TW'(1);
    end

    assign timeout = (state == ARB_WAIT) && (grant_eff == '0) &&
                     (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= {in_data, in_target, in_source};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + (AW + 1)'(1);
            if (pop)
                rd_ptr <= rd_ptr + (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pending    <= '0;
            req_out    <= '0;
            tx_valid   <= 1'b0;
            tx_target  <= '0;
            drop_count <= '0;
        end else begin
            tx_valid  <= 1'b0;
            tx_target <= '0;
            case (state)
                IDLE: begin
                    if (!empty)
                        state <= ROUTE;
                end
                ROUTE: begin
                    if (!head_ok) begin
                        drop_count <= sat_inc(drop_count);
                        state      <= IDLE;
                    end else begin
                        // A broadcast never loops back to its own source.
                        pending <= head_target & ~head_source;
                        req_out <= head_target & ~head_source;
                        state   <= ARB_WAIT;
                    end
                end
                ARB_WAIT: begin
                    if (grant_eff != '0) begin
                        tx_valid  <= 1'b1;
                        tx_target <= grant_sel;
                        req_out   <= '0;
                        state     <= TRANSMIT;
                    end else if (timeout) begin
                        pending    <= '0;
                        req_out    <= '0;
                        drop_count <= sat_inc(drop_count);
                        state      <= IDLE;
                    end
                end
                TRANSMIT: begin
                    pending <= pending_next;
                    if (pending_next == '0) begin
                        state <= IDLE;
                    end else begin
                        req_out <= pending_next;
                        state   <= ARB_WAIT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign tx_source = tx_valid ? head_source : '0;
    assign tx_data   = tx_valid ? head_data : '0;
    assign busy      = (state != IDLE) || !empty;
endmodule

// File: tb/tb_switch_port_nx.sv
// Directed bench for switch_port_nx: reset, unicast latency, multicast, broadcast, drops,
// FIFO full/wrap, ARB_WAIT timeout (SWITCH_PORT_TIMEOUT_EN) and reset mid-packet.
module tb_switch_port_nx;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_source, in_target;
    logic [7:0] in_data;
    logic [3:0] req_out, grant_in;
    logic       tx_valid;
    logic [3:0] tx_target, tx_source;
    logic [7:0] tx_data;
    logic       busy;
    logic [15:0] drop_count;

    int checks = 0;
    int errors = 0;

    logic [3:0] mon_tgt[$];
    logic [3:0] mon_src[$];
    logic [7:0] mon_data[$];

    always #5 clk = ~clk;

    switch_port_nx #(.NUM_PORTS(4), .DATA_W(8), .FIFO_DEPTH(8), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_source(in_source), .in_target(in_target), .in_data(in_data),
        .req_out(req_out), .grant_in(grant_in), .tx_valid(tx_valid),
        .tx_target(tx_target), .tx_source(tx_source), .tx_data(tx_data),
        .busy(busy), .drop_count(drop_count)
    );

    // Each transmit strobe lasts one full cycle, so the falling edge sees it exactly once.
    always @(negedge clk) begin
        if (tx_valid) begin
            mon_tgt.push_back(tx_target);
            mon_src.push_back(tx_source);
            mon_data.push_back(tx_data);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        mon_tgt.delete();
        mon_src.delete();
        mon_data.delete();
    endtask

    task automatic push_pkt(input logic [3:0] s, input logic [3:0] t, input logic [7:0] d);
        in_valid  = 1'b1;
        in_source = s;
        in_target = t;
        in_data   = d;
        tick();
        in_valid  = 1'b0;
        in_source = '0;
        in_target = '0;
        in_data   = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_source = '0; in_target = '0; in_data = '0; grant_in = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %b want 0", tx_valid); end
        checks++; if (req_out !== 4'b0000) begin errors++; $display("FAIL reset_req_out got %b want 0000", req_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL reset_drop got %0d want 0", drop_count); end
        checks++; if ({tx_target, tx_source, tx_data} !== 16'h0) begin errors++; $display("FAIL reset_tx_fields got %h want 0000", {tx_target, tx_source, tx_data}); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        grant_in = 4'b1111;
        clear_mon();
        push_pkt(4'b0001, 4'b0100, 8'hA5);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", busy); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL single_early_tx edge %0d got %b want 0", k, tx_valid); end
            if (k == 2) begin
                checks++; if (req_out !== 4'b0100) begin errors++; $display("FAIL single_req got %b want 0100", req_out); end
            end
            if (k < 2) tick();
        end
        tick();
        checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL single_tx_valid got %b want 1", tx_valid); end
        checks++; if (tx_target !== 4'b0100) begin errors++; $display("FAIL single_tx_target got %b want 0100", tx_target); end
        checks++; if (tx_source !== 4'b0001) begin errors++; $display("FAIL single_tx_source got %b want 0001", tx_source); end
        checks++; if (tx_data !== 8'hA5) begin errors++; $display("FAIL single_tx_data got %h want a5", tx_data); end
        tick();
        checks++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin errors++; $display("FAIL single_tx_end got %b/%h want 0/00", tx_valid, tx_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle busy got %b want 0", busy); end
        checks++; if (mon_tgt.size() != 1) begin errors++; $display("FAIL single_pulse_count got %0d want 1", mon_tgt.size()); end
        grant_in = 4'b0000;
    endtask

    task automatic test_multicast();
        logic [3:0] grants [3]  = '{4'b1000, 4'b0001, 4'b0100};
        logic [3:0] reqs   [3]  = '{4'b1101, 4'b0101, 4'b0100};
        grant_in = 4'b0000;
        clear_mon();
        push_pkt(4'b0010, 4'b1101, 8'h5C);
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++; if (req_out !== reqs[i]) begin errors++; $display("FAIL mc_req step %0d got %b want %b", i, req_out, reqs[i]); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mc_busy step %0d got %b want 1", i, busy); end
            grant_in = grants[i];
            tick();
            grant_in = 4'b0000;
            checks++; if (tx_valid !== 1'b1 || tx_target !== grants[i]) begin errors++; $display("FAIL mc_tx step %0d got %b/%b want 1/%b", i, tx_valid, tx_target, grants[i]); end
            checks++; if (tx_source !== 4'b0010 || tx_data !== 8'h5C) begin errors++; $display("FAIL mc_payload step %0d got %b/%h want 0010/5c", i, tx_source, tx_data); end
            checks++; if (req_out !== 4'b0000) begin errors++; $display("FAIL mc_req_tx step %0d got %b want 0000", i, req_out); end
            tick();
        end
        checks++; if (req_out !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL mc_done req/busy got %b/%b want 0000/0", req_out, busy); end
    endtask

    task automatic test_broadcast();
        logic [3:0] exp_tgt [3] = '{4'b0010, 4'b0100, 4'b1000};
        grant_in = 4'b0001;
        clear_mon();
        push_pkt(4'b0001, 4'b1111, 8'hB7);
        tick();
        tick();
        checks++; if (req_out !== 4'b1110) begin errors++; $display("FAIL bc_req got %b want 1110", req_out); end
        tick();
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL bc_self_grant tx got %b want 0", tx_valid); end
        grant_in = 4'b1111;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++; if (req_out[0] !== 1'b0) begin errors++; $display("FAIL bc_self_req cycle %0d got %b want 0", k, req_out[0]); end
        end
        grant_in = 4'b0000;
        checks++; if (mon_tgt.size() != 3) begin errors++; $display("FAIL bc_count got %0d want 3", mon_tgt.size()); end
        for (int i = 0; i < 3 && i < mon_tgt.size(); i++) begin
            checks++; if (mon_tgt[i] !== exp_tgt[i] || mon_data[i] !== 8'hB7) begin errors++; $display("FAIL bc_tx %0d got %b/%h want %b/b7", i, mon_tgt[i], mon_data[i], exp_tgt[i]); end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bc_busy got %b want 0", busy); end
    endtask

    task automatic test_invalid();
        grant_in = 4'b1111;
        clear_mon();
        push_pkt(4'b0011, 4'b0100, 8'h01);
        push_pkt(4'b0001, 4'b0000, 8'h02);
        push_pkt(4'b0001, 4'b0011, 8'h03);
        push_pkt(4'b0100, 4'b0001, 8'h3C);
        repeat (20) tick();
        grant_in = 4'b0000;
        checks++; if (drop_count !== 16'd3) begin errors++; $display("FAIL inv_drop got %0d want 3", drop_count); end
        checks++; if (mon_tgt.size() != 1) begin errors++; $display("FAIL inv_count got %0d want 1", mon_tgt.size()); end
        if (mon_tgt.size() > 0) begin
            checks++; if (mon_tgt[0] !== 4'b0001 || mon_src[0] !== 4'b0100 || mon_data[0] !== 8'h3C) begin errors++; $display("FAIL inv_follow got %b/%b/%h want 0001/0100/3c", mon_tgt[0], mon_src[0], mon_data[0]); end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL inv_busy got %b want 0", busy); end
    endtask

    task automatic test_fifo_full();
        grant_in = 4'b0000;
        clear_mon();
        for (int i = 0; i < 9; i++) begin
            checks++; if (in_ready !== (i < 8)) begin errors++; $display("FAIL full_ready push %0d got %b want %b", i, in_ready, (i < 8)); end
            push_pkt(4'b0001, 4'b0010, 8'(i));
        end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_after got %b want 0", in_ready); end
        checks++; if (mon_tgt.size() != 0) begin errors++; $display("FAIL full_no_tx got %0d want 0", mon_tgt.size()); end
        grant_in = 4'b1111;
        for (int k = 0; k < 100 && mon_data.size() < 8; k++) tick();
        repeat (20) tick();
        checks++; if (mon_data.size() != 8) begin errors++; $display("FAIL full_drain_count got %0d want 8", mon_data.size()); end
        for (int i = 0; i < 8 && i < mon_data.size(); i++) begin
            checks++; if (mon_data[i] !== 8'(i)) begin errors++; $display("FAIL full_order %0d got %h want %h", i, mon_data[i], 8'(i)); end
        end
        clear_mon();
        for (int i = 0; i < 8; i++) begin
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL wrap_ready push %0d got %b want 1", i, in_ready); end
            push_pkt(4'b0001, 4'b0010, 8'(8'h10 + i));
        end
        for (int k = 0; k < 100 && mon_data.size() < 8; k++) tick();
        repeat (5) tick();
        checks++; if (mon_data.size() != 8) begin errors++; $display("FAIL wrap_count got %0d want 8", mon_data.size()); end
        for (int i = 0; i < 8 && i < mon_data.size(); i++) begin
            checks++; if (mon_data[i] !== 8'(8'h10 + i)) begin errors++; $display("FAIL wrap_order %0d got %h want %h", i, mon_data[i], 8'(8'h10 + i)); end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wrap_busy got %b want 0", busy); end
        grant_in = 4'b0000;
    endtask

    task automatic test_timeout();
        grant_in = 4'b0000;
        clear_mon();
        push_pkt(4'b0001, 4'b0010, 8'h77);
        tick();
        tick();
        checks++; if (req_out !== 4'b0010) begin errors++; $display("FAIL to_req got %b want 0010", req_out); end
`ifdef SWITCH_PORT_TIMEOUT_EN
        repeat (63) tick();
        checks++; if (req_out !== 4'b0010 || busy !== 1'b1) begin errors++; $display("FAIL to_before req/busy got %b/%b want 0010/1", req_out, busy); end
        tick();
        checks++; if (busy !== 1'b0 || req_out !== 4'b0000) begin errors++; $display("FAIL to_expire busy/req got %b/%b want 0/0000", busy, req_out); end
        checks++; if (drop_count !== 16'd4) begin errors++; $display("FAIL to_drop got %0d want 4", drop_count); end
`else
        repeat (200) tick();
        checks++; if (req_out !== 4'b0010 || busy !== 1'b1) begin errors++; $display("FAIL to_wait req/busy got %b/%b want 0010/1", req_out, busy); end
        checks++; if (drop_count !== 16'd3) begin errors++; $display("FAIL to_drop got %0d want 3", drop_count); end
`endif
        checks++; if (mon_tgt.size() != 0) begin errors++; $display("FAIL to_no_tx got %0d want 0", mon_tgt.size()); end
        grant_in = 4'b1111;
        repeat (10) tick();
        grant_in = 4'b0000;
    endtask

    task automatic test_reset_mid();
        grant_in = 4'b0000;
        push_pkt(4'b0001, 4'b0100, 8'h11);
        push_pkt(4'b0010, 4'b0001, 8'h22);
        tick();
        checks++; if (req_out !== 4'b0100) begin errors++; $display("FAIL rm_req got %b want 0100", req_out); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (req_out !== 4'b0000 || busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rm_async req/busy/ready got %b/%b/%b want 0000/0/1", req_out, busy, in_ready); end
        checks++; if (drop_count !== 16'd0 || tx_valid !== 1'b0) begin errors++; $display("FAIL rm_async drop/tx got %0d/%b want 0/0", drop_count, tx_valid); end
        clear_mon();
        @(posedge clk);
        #1 rst_n = 1'b1;
        grant_in = 4'b1111;
        repeat (20) tick();
        checks++; if (mon_tgt.size() != 0) begin errors++; $display("FAIL rm_no_tx got %0d want 0", mon_tgt.size()); end
        checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rm_after busy/ready got %b/%b want 0/1", busy, in_ready); end
        grant_in = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_single();
        test_multicast();
        test_broadcast();
        test_invalid();
        test_fifo_full();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
